register_bank: RTL

- Eight-entry, 16-bit general-purpose register bank for the register-bank datapath.
- Sits directly upstream of the 8:1 16-bit multiplexer: q0..q7 drive mux inputs input0..input7, and the mux's 3-bit control selects the operand.
- Provides synchronous single-port writes with a registered acknowledge, plus a sequenced clear operation that zeroes one register per cycle under a busy flag.

---
 rtl/register_bank.sv | 96 +++++++++
 1 files changed

// File: rtl/register_bank.sv
// Eight-entry register bank with single-port writes, a registered write
// acknowledge, and a clear sequence that zeroes one register per cycle while busy.
module register_bank #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [2:0]       write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             clear_req,
    output logic             write_ack,
    output logic             busy,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic             write_ack_q, write_ack_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        count_d     = count_q;
        write_ack_d = 1'b0;
        regs_d      = regs_q;

        case (state_q)
            IDLE: begin
                if (write_enable) begin
                    regs_d[write_addr] = write_data;
                    write_ack_d        = 1'b1;
                end
                // A same-cycle write still lands; the sweep zeroes it later.
                if (clear_req) begin
                    state_d = CLEAR;
                    count_d = 3'd0;
                end
            end
            CLEAR: begin
                regs_d[count_q] = '0;
                count_d         = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 3'd0;
            write_ack_q <= 1'b0;
            // NOTE: the register array is reset on purpose, since all outputs must read zero after reset.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            write_ack_q <= write_ack_d;
            regs_q      <= regs_d;
        end
    end

    assign write_ack = write_ack_q;
    assign busy      = (state_q == CLEAR);

    assign q0 = regs_q[0];
    assign q1 = regs_q[1];
    assign q2 = regs_q[2];
    assign q3 = regs_q[3];
    assign q4 = regs_q[4];
    assign q5 = regs_q[5];
    assign q6 = regs_q[6];
    assign q7 = regs_q[7];

endmodule
